// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the CPU load/store path (port 0,
// cpu_*) and a debug/loader port (port 1, dbg_*). Each access is sequenced as
// IDLE (grant) -> BUSY (memory wait) -> RESP (one-cycle ack). Misaligned
// accesses skip memory and complete with err. An access that sees no
// mem_ready within TIMEOUT BUSY cycles is aborted with err and rdata=0.
//
// Parameters:
//   TIMEOUT  max BUSY cycles before abort (1..255)
//   AW       address width
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/dmtype    CPU request (req held until cpu_ack)
//   cpu_rdata, cpu_ack, cpu_stall   CPU response; stall = req & ~ack
//   dbg_req/we/addr/wdata/dmtype    debug/loader request
//   dbg_rdata, dbg_ack              debug/loader response
//   err                             with an ack: access was aborted
//   mem_req/we/addr/wdata/dmtype    memory strobe and request fields
//   mem_rdata, mem_ready            memory read data and completion
//
// dmtype: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
//
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking (CPU wins
// the first tie after reset). Without it, dbg always beats cpu on a tie.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [2:0]    cpu_dmtype,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  // debug/loader port
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  input  logic [2:0]    dbg_dmtype,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_ack,
  // shared status
  output logic          err,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_dmtype,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Last counter value at which BUSY may still wait for mem_ready.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic        winner_reg;  // 0 = cpu, 1 = dbg

  logic          grant_dbg;
  logic          any_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [2:0]    sel_dmtype;
  logic          sel_misaligned;
  logic [31:0]   busy_rdata;

  assign any_req = cpu_req | dbg_req;

`ifdef DMEM_ARB_RR_EN
  // 1 = dbg was granted last; reset to 1 so the CPU takes the first tie.
  logic last_grant_reg;
  assign grant_dbg = dbg_req & (~cpu_req | ~last_grant_reg);
`else
  assign grant_dbg = dbg_req;
`endif

  assign sel_we     = grant_dbg ? dbg_we     : cpu_we;
  assign sel_addr   = grant_dbg ? dbg_addr   : cpu_addr;
  assign sel_wdata  = grant_dbg ? dbg_wdata  : cpu_wdata;
  assign sel_dmtype = grant_dbg ? dbg_dmtype : cpu_dmtype;

  always_comb begin
    sel_misaligned = 1'b0;
    case (sel_dmtype)
      3'b000:         sel_misaligned = |sel_addr[1:0];
      3'b001, 3'b010: sel_misaligned = sel_addr[0];
      default:        sel_misaligned = 1'b0;
    endcase
  end

  // A timeout leaves the BUSY state without mem_ready and must return zero.
  assign busy_rdata = mem_ready ? mem_rdata : 32'd0;

  assign cpu_stall = cpu_req & ~cpu_ack;

  // The mem_* output registers double as the latched copy of the granted
  // request: they are loaded once at grant and held through BUSY, so later
  // changes on the request inputs cannot reach memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 8'd0;
      winner_reg <= 1'b0;
      cpu_rdata  <= 32'd0;
      cpu_ack    <= 1'b0;
      dbg_rdata  <= 32'd0;
      dbg_ack    <= 1'b0;
      err        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      mem_dmtype <= 3'd0;
`ifdef DMEM_ARB_RR_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            winner_reg <= grant_dbg;
`ifdef DMEM_ARB_RR_EN
            last_grant_reg <= grant_dbg;
`endif
            if (sel_misaligned) begin
              // Complete immediately with an error; memory is not touched.
              state_reg <= RESP;
              err       <= 1'b1;
              if (grant_dbg) begin
                dbg_ack   <= 1'b1;
                dbg_rdata <= 32'd0;
              end else begin
                cpu_ack   <= 1'b1;
                cpu_rdata <= 32'd0;
              end
            end else begin
              state_reg  <= BUSY;
              cnt_reg    <= 8'd0;
              mem_req    <= 1'b1;
              mem_we     <= sel_we;
              mem_addr   <= sel_addr;
              mem_wdata  <= sel_wdata;
              mem_dmtype <= sel_dmtype;
            end
          end
        end

        BUSY: begin
          cnt_reg <= cnt_reg + 8'd1;
          // mem_ready takes precedence over a timeout in the same cycle.
          if (mem_ready || (cnt_reg == CNT_LAST)) begin
            state_reg  <= RESP;
            err        <= ~mem_ready;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            mem_dmtype <= 3'd0;
            if (winner_reg) begin
              dbg_ack   <= 1'b1;
              dbg_rdata <= busy_rdata;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= busy_rdata;
            end
          end
        end

        RESP: begin
          state_reg <= IDLE;
          cpu_ack   <= 1'b0;
          dbg_ack   <= 1'b0;
          err       <= 1'b0;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Each group of requests is planned at transaction level: the service order
// follows the priority rule, and each access occupies (grant cycle, N BUSY
// cycles, ack cycle) with N = 0 when misaligned, latency+1 when memory answers
// in time, or TIMEOUT otherwise. The plan fills per-cycle expectation tables
// and the mem_ready/mem_rdata schedule; one compare process checks the DUT
// against the tables on every cycle. Directed groups add literal checks.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int TO   = 4;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic [2:0]  cpu_dmtype = 3'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = 32'd0, dbg_wdata = 32'd0;
  logic [2:0]  dbg_dmtype = 3'd0;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_dmtype;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  dmem_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_dmtype(cpu_dmtype), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_dmtype(dbg_dmtype), .dbg_rdata(dbg_rdata),
    .dbg_ack(dbg_ack),
    .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_dmtype(mem_dmtype),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Per-cycle expectation tables and memory-side schedule.
  bit        exp_zero   [MAXC];
  bit        exp_mem_req[MAXC];
  bit        exp_we     [MAXC];
  bit [31:0] exp_addr   [MAXC];
  bit [31:0] exp_wdata  [MAXC];
  bit [2:0]  exp_dmt    [MAXC];
  bit        exp_cack   [MAXC];
  bit        exp_dack   [MAXC];
  bit        exp_err    [MAXC];
  bit        exp_rd_chk [MAXC];
  bit [31:0] exp_rdata  [MAXC];
  bit        drv_ready  [MAXC];
  bit [31:0] drv_rdata  [MAXC];

  // Per-port request description for the next group (0 = cpu, 1 = dbg).
  bit        p_en[2], p_we[2], p_drop[2], p_chg[2];
  bit [31:0] p_addr[2], p_wdata[2], p_rdv[2];
  bit [2:0]  p_dmt[2];
  int        p_lat[2];

`ifdef DMEM_ARB_RR_EN
  bit m_last = 1'b1;  // 1 = dbg granted last
`endif

  // Observations recorded by the compare process, used by directed checks.
  int        grp_start;
  int        obs_ack_cyc[2];
  bit [31:0] obs_rdata[2];
  bit        obs_err[2];
  int        obs_first;
  int        obs_nacks;
  int        obs_memreq_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic bit is_mis(input bit [2:0] t, input bit [31:0] a);
    if (t == 3'd0) return a[1:0] != 2'b00;
    if (t == 3'd1 || t == 3'd2) return a[0];
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      if (exp_zero[cyc]) begin
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_dmtype", 32'(mem_dmtype), 32'd0);
      end
      chk("mem_req", 32'(mem_req), 32'(exp_mem_req[cyc]));
      chk("cpu_ack", 32'(cpu_ack), 32'(exp_cack[cyc]));
      chk("dbg_ack", 32'(dbg_ack), 32'(exp_dack[cyc]));
      chk("err", 32'(err), 32'(exp_err[cyc]));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~exp_cack[cyc]));
      if (exp_mem_req[cyc]) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
        chk("mem_addr", mem_addr, exp_addr[cyc]);
        chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
        chk("mem_dmtype", 32'(mem_dmtype), 32'(exp_dmt[cyc]));
      end
      if (exp_cack[cyc] && exp_rd_chk[cyc]) chk("cpu_rdata", cpu_rdata, exp_rdata[cyc]);
      if (exp_dack[cyc] && exp_rd_chk[cyc]) chk("dbg_rdata", dbg_rdata, exp_rdata[cyc]);

      if (mem_req === 1'b1) obs_memreq_cnt++;
      if (cpu_ack === 1'b1) begin
        obs_ack_cyc[0] = cyc; obs_rdata[0] = cpu_rdata; obs_err[0] = err;
        obs_nacks++;
        if (obs_first < 0) obs_first = 0;
        $display("txn cyc=%0d port=cpu err=%0b rdata=%h", cyc, err, cpu_rdata);
      end
      if (dbg_ack === 1'b1) begin
        obs_ack_cyc[1] = cyc; obs_rdata[1] = dbg_rdata; obs_err[1] = err;
        obs_nacks++;
        if (obs_first < 0) obs_first = 1;
        $display("txn cyc=%0d port=dbg err=%0b rdata=%h", cyc, err, dbg_rdata);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic clear_obs();
    obs_ack_cyc[0] = -1; obs_ack_cyc[1] = -1;
    obs_rdata[0] = '1;   obs_rdata[1] = '1;
    obs_err[0] = 1'b0;   obs_err[1] = 1'b0;
    obs_first = -1; obs_nacks = 0; obs_memreq_cnt = 0;
  endtask

  // Memory-side stimulus for the current cycle: the planned answer, or
  // random noise where the block is not waiting on memory (must be ignored).
  task automatic drive_mem();
    if (drv_ready[cyc]) begin
      mem_ready = 1'b1;
      mem_rdata = drv_rdata[cyc];
    end else begin
      mem_ready = exp_mem_req[cyc] ? 1'b0 : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic set_req(input int p, input bit v);
    if (p == 0) cpu_req = v; else dbg_req = v;
  endtask

  task automatic scramble(input int p);
    if (p == 0) begin
      cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      cpu_dmtype = 3'($urandom_range(0, 4));
    end else begin
      dbg_we = 1'($urandom); dbg_addr = $urandom; dbg_wdata = $urandom;
      dbg_dmtype = 3'($urandom_range(0, 4));
    end
  endtask

  task automatic set_port(input int p, input bit we, input bit [31:0] addr,
                          input bit [31:0] wdata, input bit [2:0] dmt,
                          input int lat, input bit [31:0] rdv);
    p_en[p] = 1'b1; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata;
    p_dmt[p] = dmt; p_lat[p] = lat; p_rdv[p] = rdv;
    p_drop[p] = 1'b0; p_chg[p] = 1'b0;
  endtask

  task automatic rand_port(input int p);
    p_en[p]    = 1'b1;
    p_we[p]    = 1'($urandom);
    p_addr[p]  = ($urandom & 32'h0000_0FFC) |
                 (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    p_wdata[p] = $urandom;
    p_dmt[p]   = 3'($urandom_range(0, 4));
    p_lat[p]   = $urandom_range(0, 5);
    p_rdv[p]   = $urandom;
    p_drop[p]  = ($urandom_range(0, 4) == 0);
    p_chg[p]   = ($urandom_range(0, 3) == 0);
  endtask

  // Plan and run one group starting in the current (idle) cycle.
  task automatic run_group();
    int order[2];
    int g[2], a[2];
    bit served[2];
    int n, t, p, b, c;
    bit mis, tmo;
    c = cyc;
    grp_start = c;
    clear_obs();
    n = 0;
    order[0] = 0; order[1] = 0;
    if (p_en[0] && p_en[1]) begin
      n = 2;
`ifdef DMEM_ARB_RR_EN
      if (m_last) begin order[0] = 0; order[1] = 1; end
      else        begin order[0] = 1; order[1] = 0; end
`else
      order[0] = 1; order[1] = 0;
`endif
    end else if (p_en[0]) begin
      n = 1; order[0] = 0;
    end else if (p_en[1]) begin
      n = 1; order[0] = 1;
    end
    served[0] = 1'b0; served[1] = 1'b0;
    g[0] = -10; g[1] = -10; a[0] = -10; a[1] = -10;
    t = c;
    for (int k = 0; k < n; k++) begin
      p = order[k];
      served[p] = 1'b1;
      g[p] = t;
`ifdef DMEM_ARB_RR_EN
      m_last = (p == 1);
`endif
      mis = is_mis(p_dmt[p], p_addr[p]);
      tmo = !mis && (p_lat[p] >= TO);
      b = mis ? 0 : (tmo ? TO : p_lat[p] + 1);
      for (int j = 1; j <= b; j++) begin
        exp_mem_req[t+j] = 1'b1;
        exp_we[t+j]      = p_we[p];
        exp_addr[t+j]    = p_addr[p];
        exp_wdata[t+j]   = p_wdata[p];
        exp_dmt[t+j]     = p_dmt[p];
      end
      if (!mis && !tmo) begin
        drv_ready[t+1+p_lat[p]] = 1'b1;
        drv_rdata[t+1+p_lat[p]] = p_rdv[p];
      end
      a[p] = t + b + 1;
      if (p == 0) exp_cack[a[p]] = 1'b1; else exp_dack[a[p]] = 1'b1;
      exp_err[a[p]]    = mis || tmo;
      exp_rd_chk[a[p]] = !mis;
      exp_rdata[a[p]]  = tmo ? 32'd0 : p_rdv[p];
      t = a[p] + 1;
    end

    cpu_we = p_we[0]; cpu_addr = p_addr[0]; cpu_wdata = p_wdata[0]; cpu_dmtype = p_dmt[0];
    dbg_we = p_we[1]; dbg_addr = p_addr[1]; dbg_wdata = p_wdata[1]; dbg_dmtype = p_dmt[1];
    cpu_req = p_en[0];
    dbg_req = p_en[1];
    p_en[0] = 1'b0; p_en[1] = 1'b0;
    if (n == 0) return;

    step();
    while (cyc < t) begin
      for (int q = 0; q < 2; q++) begin
        if (served[q]) begin
          if (cyc == g[q] + 1 && p_drop[q]) set_req(q, 1'b0);
          if (cyc == g[q] + 1 && p_chg[q])  scramble(q);
          if (cyc == a[q] + 1)              set_req(q, 1'b0);
        end
      end
      step();
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int c, mode;
    p_en[0] = 1'b0; p_en[1] = 1'b0;
    for (int i = 1; i <= 3; i++) exp_zero[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_mem();
    idle(2);

    // Aligned CPU load answered in the first BUSY cycle.
    set_port(0, 1'b0, 32'h10, 32'h0, 3'd0, 0, 32'hDEADBEEF);
    run_group();
    chk("load_ack_latency", 32'(obs_ack_cyc[0] - grp_start), 32'd2);
    chk("load_rdata", obs_rdata[0], 32'hDEADBEEF);
    chk("load_err", 32'(obs_err[0]), 32'd0);
    chk("load_memreq_cycles", 32'(obs_memreq_cnt), 32'd1);
    idle(1);

    // CPU store, memory answers in the 3rd BUSY cycle.
    set_port(0, 1'b1, 32'h20, 32'h12345678, 3'd0, 2, 32'h0);
    run_group();
    chk("store_ack_latency", 32'(obs_ack_cyc[0] - grp_start), 32'd4);
    chk("store_memreq_cycles", 32'(obs_memreq_cnt), 32'd3);
    chk("store_err", 32'(obs_err[0]), 32'd0);

    // dbg load answered in the last cycle before timeout.
    set_port(1, 1'b0, 32'h44, 32'h0, 3'd4, TO - 1, 32'hCAFE0001);
    run_group();
    chk("late_ready_memreq_cycles", 32'(obs_memreq_cnt), 32'(TO));
    chk("late_ready_err", 32'(obs_err[1]), 32'd0);
    chk("late_ready_rdata", obs_rdata[1], 32'hCAFE0001);
    idle(1);

    // Two ties in a row.
    for (int k = 0; k < 2; k++) begin
      set_port(0, 1'b0, 32'h100, 32'h0, 3'd0, 0, 32'hAAAA0000 + 32'(k));
      set_port(1, 1'b1, 32'h200, 32'h55, 3'd3, 1, 32'h0);
      run_group();
`ifdef DMEM_ARB_RR_EN
      chk("tie_first_port", 32'(obs_first), 32'd0);
`else
      chk("tie_first_port", 32'(obs_first), 32'd1);
`endif
      chk("tie_ack_count", 32'(obs_nacks), 32'd2);
    end

    // Misaligned word (cpu) and half (dbg).
    set_port(0, 1'b0, 32'h22, 32'h0, 3'd0, 0, 32'h1);
    run_group();
    chk("mis_word_ack_latency", 32'(obs_ack_cyc[0] - grp_start), 32'd1);
    chk("mis_word_err", 32'(obs_err[0]), 32'd1);
    chk("mis_word_memreq_cycles", 32'(obs_memreq_cnt), 32'd0);
    set_port(1, 1'b1, 32'h21, 32'h9, 3'd1, 0, 32'h1);
    run_group();
    chk("mis_half_ack_latency", 32'(obs_ack_cyc[1] - grp_start), 32'd1);
    chk("mis_half_err", 32'(obs_err[1]), 32'd1);
    chk("mis_half_memreq_cycles", 32'(obs_memreq_cnt), 32'd0);

    // Timeout: memory never answers.
    set_port(0, 1'b0, 32'h30, 32'h0, 3'd0, 100, 32'h77);
    run_group();
    chk("timeout_memreq_cycles", 32'(obs_memreq_cnt), 32'(TO));
    chk("timeout_err", 32'(obs_err[0]), 32'd1);
    chk("timeout_rdata", obs_rdata[0], 32'd0);
    chk("timeout_ack_latency", 32'(obs_ack_cyc[0] - grp_start), 32'(TO + 1));

    // Reset pulse during BUSY, then a normal access.
    c = cyc;
    clear_obs();
    cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0; cpu_dmtype = 3'd0;
    cpu_req = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      exp_mem_req[c+j] = 1'b1; exp_we[c+j] = 1'b0; exp_addr[c+j] = 32'h40;
      exp_wdata[c+j] = 32'h0; exp_dmt[c+j] = 3'd0;
    end
    exp_zero[c+3] = 1'b1;
    step();
    step();
    reset = 1'b1;
    cpu_req = 1'b0;
`ifdef DMEM_ARB_RR_EN
    m_last = 1'b1;
`endif
    step();
    reset = 1'b0;
    chk("reset_busy_memreq_cycles", 32'(obs_memreq_cnt), 32'd2);
    chk("reset_busy_no_ack", 32'(obs_nacks), 32'd0);
    set_port(0, 1'b0, 32'h48, 32'h0, 3'd0, 0, 32'h0BADF00D);
    run_group();
    chk("after_reset_ack_latency", 32'(obs_ack_cyc[0] - grp_start), 32'd2);
    chk("after_reset_rdata", obs_rdata[0], 32'h0BADF00D);

    // Randomized groups.
    for (int i = 0; i < 300 && cyc < MAXC - 60; i++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0 || mode >= 2) rand_port(0);
      if (mode == 1 || mode >= 2) rand_port(1);
      run_group();
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store path (port 0) and a debug/loader port (port 1).
- Sequences each access as request, memory wait, then a one-cycle ack. It also enforces alignment and aborts accesses that time out.
- Sits between the CPU's Addr_out/Data_out/mem_w/DMType outputs and the data memory. A stall output lets the CPU freeze its PC while an access is pending.

Parameters:
- TIMEOUT, 16: maximum cycles spent in BUSY waiting for mem_ready before the access is aborted; legal range 1..255.
- AW, 32: address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request (level); held until cpu_ack.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_dmtype  in  3  access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- cpu_rdata  out  32  load data returned to the CPU; valid while cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational).
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_dmtype, dbg_rdata, dbg_ack  same meanings as the cpu_* ports, for the debug/loader port.
- err  out  1  high together with an ack when the access was aborted (misaligned or timeout).
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_dmtype  out  3  access type passed through to memory.
- mem_rdata  in  32  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completion indication.

Behaviour:
- Reset values: state=IDLE; every output is 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_dmtype, cpu_rdata, dbg_rdata, both acks, err). Timeout counter=0.
- State IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select a winner (priority rule below) and latch its we, addr, wdata and dmtype into internal registers.
  - Misaligned check: word access with addr[1:0]!=0, or half access with addr[0]!=0. If misaligned, go to RESP with err=1; memory is never touched.
  - If aligned, go to BUSY. mem_req rises on the cycle after the grant decision.
- State BUSY:
  - mem_req=1 and mem_* are driven from the latched registers, held stable for the whole state.
  - On mem_ready=1: capture mem_rdata into the winner's rdata register (writes capture it too; the value is don't-care), go to RESP with err=0.
  - If the counter reaches TIMEOUT-1 without mem_ready: go to RESP with err=1 and rdata=0.
  - The counter increments every BUSY cycle and clears on entering BUSY.
- State RESP:
  - The winner's ack=1 for exactly one cycle; err is valid in the same cycle; mem_req=0.
  - The next state is always IDLE. The loser's ack stays 0.
- Minimum latency, req to ack:
  - Aligned access with mem_ready in the first BUSY cycle: ack is high in the 3rd cycle after req is sampled (IDLE, BUSY, RESP).
  - Misaligned access: ack is high in the 2nd cycle.
- A req still high in the IDLE cycle after RESP counts as a new transaction. Requesters must drop req in the cycle after ack if they do not want another access.
- mem_ready outside BUSY is ignored.
- A requester dropping req mid-transaction has no effect; the transaction completes and its ack is still issued.
- Changes on the request fields after the grant are ignored (the latched values are used).
- Reset asserted in any state returns the block to IDLE on the next edge with all outputs 0. No ack is issued for the aborted transaction.
- Fixed priority (default): dbg beats cpu when both request in the same IDLE cycle.
- Counter width is 8 bits; no wrap is possible because TIMEOUT<=255.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin priority. A 1-bit last_grant register (reset value 1, so the CPU wins the first tie) updates on every grant. On a tie, the port not granted last time wins.
- Undefined: fixed priority, dbg over cpu; no last_grant register is built.

Test Plan:
- Aligned CPU load: cpu_req=1, cpu_addr=0x10, dmtype=000, mem_ready in the first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x10 and mem_we=0 during BUSY; cpu_ack is a 1-cycle pulse in cycle 3 with cpu_rdata=0xDEADBEEF and err=0; cpu_stall high in cycles 1-2.
- CPU store with wait states: cpu_we=1, cpu_addr=0x20, wdata=0x12345678, mem_ready after 3 BUSY cycles -> mem_* held stable for 3 cycles; ack on the cycle after mem_ready.
- Tie: cpu_req and dbg_req both rise in the same cycle -> without the macro: dbg served first, cpu second, two separate acks. With DMEM_ARB_RR_EN: cpu first, dbg second, and the next tie goes to cpu again.
- Misaligned accesses: word at 0x22, and half at 0x21 -> each gives ack+err=1 in cycle 2; mem_req never asserts.
- Timeout: TIMEOUT=4 and mem_ready held 0 -> exactly 4 BUSY cycles, then ack with err=1 and rdata=0.
- Reset mid-BUSY: assert reset for 1 cycle during BUSY -> the next cycle shows mem_req=0, ack=0, state IDLE. A later request is then served normally.
